pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Sequential consumer of the next-PC selection in the RV32I single-cycle core.
- Holds the architectural PC and registers next_pc when the core commits an instruction.
- Fetches the instruction at pc over a req/ready instruction-memory handshake and presents it to decode with a valid flag.
- Detects misaligned targets and memory timeouts, and enters a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, maximum cycles imem_req may stay unanswered before a timeout fault.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- next_pc  in  32  selected next PC from the PC mux.
- pc_we  in  1  core commits the current instruction; load next_pc.
- stall  in  1  core hold; blocks pc_we.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, feeds the PC mux.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ready  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  instr is valid for the current pc.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned target, 10 fetch timeout.
- fault_addr  out  32  offending target or fetch address.

Behaviour:
- Clock and reset are fixed:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - Assertion at any time, including mid-fetch, immediately forces:
    - pc=RESET_PC
    - state=RST
    - imem_req=0
    - instr=32'h0000_0013 (NOP)
    - instr_valid=0
    - fault=0, fault_cause=00, fault_addr=0
    - wait counter=0
- FSM states: RST, REQ, VALID, FAULT.
- RST: leave after the first clock edge following rst_n deassertion; go to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - If imem_ready is sampled high at the edge:
    - instr<=imem_rdata, instr_valid<=1, counter cleared, go to VALID.
    - This allows zero-wait memory (ready in the same cycle as the request) to give a one-cycle fetch.
  - Otherwise the counter increments.
  - Counter reaching MAX_WAIT:
    - Go to FAULT with fault_cause=10 and fault_addr=pc.
  - Counter width is $clog2(MAX_WAIT+1).
- VALID:
  - imem_req=0, instr_valid=1.
  - On pc_we=1 && stall=0 && next_pc[1:0]==0:
    - pc<=next_pc, instr_valid<=0, go to REQ.
    - Next fetch request is issued in the following cycle.
  - On pc_we=1 && stall=0 && next_pc[1:0]!=0:
    - pc unchanged, go to FAULT with fault_cause=01 and fault_addr=next_pc.
  - If stall=1, pc_we is ignored; state and outputs hold.
- FAULT:
  - imem_req=0, instr_valid=0, fault=1.
  - Sticky; exited only by reset.
  - pc_we is ignored.
- pc_we in RST or REQ is ignored.
- pc_plus4 is computed modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0.
- next_pc equal to pc (self-loop) is legal and causes a refetch of the same address.
- imem_ready outside REQ is ignored; imem_rdata is sampled only in REQ.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count (32 bit): increments on each REQ->VALID transition.
  - Adds output wait_count (32 bit): increments on each REQ cycle without imem_ready.
  - Both counters reset to 0, wrap at 2^32, and freeze in FAULT.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - fetch_state_t enum {RST, REQ, VALID, FAULT}
  - fault_cause_t enum {FC_NONE=2'b00, FC_MISALIGN=2'b01, FC_TIMEOUT=2'b10}
  - localparam NOP_INSTR=32'h0000_0013
  - localparam PC_STEP=4
- One natural sub-module: fetch_wait_timer, holding the wait counter and timeout compare (inputs: count enable, clear; output: expired).
- Everything else stays flat in pc_fetch_unit.

Test Plan:
- Reset release with RESET_PC=32'h100 and zero-wait memory (imem_ready=1): first edge RST->REQ; next edge instr=imem_rdata, instr_valid=1, pc=32'h100, pc_plus4=32'h104.
- Normal commit: in VALID, pc_we=1 with next_pc=32'h104 -> pc=32'h104, instr_valid=0; then imem_req=1 with imem_addr=32'h104.
- Stall: in VALID, stall=1 and pc_we=1 with next_pc=32'h200 for 3 cycles -> pc stays 32'h104, instr_valid stays 1; releasing stall then commits 32'h200.
- Misaligned target: pc_we with next_pc=32'h202 -> fault=1, fault_cause=01, fault_addr=32'h202; pc unchanged; later pc_we pulses are ignored.
- Timeout: imem_ready held 0 for MAX_WAIT=16 cycles -> fault_cause=10, fault_addr=pc, imem_req drops to 0.
- Async reset mid-REQ: rst_n pulsed low between clock edges -> outputs return to reset values immediately, without waiting for an edge; with FETCH_PERF_CNT_EN, fetch_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared types and constants for the RV32I fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      RST   = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   // Fault cause encoding presented on fault_cause
   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_TIMEOUT  = 2'b10
   } fault_cause_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_wait_timer
// Brief    : Counts unanswered fetch-request cycles and flags a timeout.
//            expired is asserted in the cycle whose count_en would bring the
//            counter to MAX_WAIT, so the owner can leave on that same edge.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_wait_timer #(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count;

   // Wait counter: cleared on request, saturates at MAX_WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != CW'(MAX_WAIT))) begin
         count <= count + 1'b1;
      end
   end

   assign expired = count_en && !clear && (count == CW'(MAX_WAIT - 1));

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Architectural PC register and instruction fetch FSM with
//            misaligned-target and fetch-timeout sticky fault detection.
//            Optional macro FETCH_PERF_CNT_EN adds fetch_count/wait_count.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        pc_we,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] wait_count
`endif
);

   fetch_state_t state;
   fetch_state_t state_next;
   fault_cause_t cause;
   logic         timeout;
   logic         commit;
   logic         aligned;

   // Core may only advance the PC while an instruction is on offer
   assign commit  = (state == VALID) && pc_we && !stall;
   assign aligned = (next_pc[1:0] == 2'b00);

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_en ((state == REQ) && !imem_ready),
      .clear    ((state != REQ) || imem_ready),
      .expired  (timeout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         RST:   state_next = REQ;
         REQ: begin
            if (imem_ready) begin
               state_next = VALID;
            end else if (timeout) begin
               state_next = FAULT;
            end
         end
         VALID: begin
            if (commit) begin
               state_next = aligned ? REQ : FAULT;
            end
         end
         FAULT: state_next = FAULT;
         default: state_next = RST;
      endcase
   end

   // PC, fetched instruction and fault capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         instr      <= NOP_INSTR;
         cause      <= FC_NONE;
         fault_addr <= 32'h0000_0000;
      end else begin
         if ((state == REQ) && imem_ready) begin
            instr <= imem_rdata;
         end
         if ((state == REQ) && !imem_ready && timeout) begin
            cause      <= FC_TIMEOUT;
            fault_addr <= pc;
         end
         if (commit) begin
            if (aligned) begin
               pc <= next_pc;
            end else begin
               cause      <= FC_MISALIGN;
               fault_addr <= next_pc;
            end
         end
      end
   end

   assign pc_plus4    = pc + PC_STEP;
   assign imem_addr   = pc;
   assign imem_req    = (state == REQ);
   assign instr_valid = (state == VALID);
   assign fault       = (state == FAULT);
   assign fault_cause = cause;

`ifdef FETCH_PERF_CNT_EN
   // Performance counters; only REQ advances them, so they freeze in FAULT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= 32'h0000_0000;
         wait_count  <= 32'h0000_0000;
      end else if (state == REQ) begin
         if (imem_ready) begin
            fetch_count <= fetch_count + 32'd1;
         end else begin
            wait_count <= wait_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
